// File: rtl/px_rd_sched.sv
// rtl/px_rd_sched.sv - ordered token read scheduler between pixel decoders and the pixel-memory read port
module px_rd_sched #(
  parameter int NDEC = 8,
  parameter int AW   = 20,
  parameter int DW   = 16,
  parameter int BW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         decoder_used,
  input  logic [NDEC-1:0]    dec_req,
  input  logic [NDEC*AW-1:0] dec_addr,
  input  logic [NDEC*BW-1:0] dec_burst,
  output logic [NDEC-1:0]    dec_grant,
  output logic [NDEC-1:0]    dec_vld,
  input  logic [NDEC-1:0]    dec_rdy,
  output logic [DW-1:0]      dec_data,
  output logic               mem_cmd_vld,
  input  logic               mem_cmd_rdy,
  output logic [AW-1:0]      mem_cmd_addr,
  output logic [BW-1:0]      mem_cmd_burst,
  input  logic               mem_rd_vld,
  output logic               mem_rd_rdy,
  input  logic [DW-1:0]      mem_rd_data,
  output logic               busy,
  output logic [2:0]         tok
);

  typedef enum logic [1:0] {IDLE, CMD, BURST} stateT;

  stateT         state;
  stateT         stateNext;
  logic [2:0]    usedLat;
  logic [BW-1:0] cnt;
  logic          tokValid;
  logic          beatXfer;

  // tok beyond the active count means decoder_used was lowered; IDLE resets it instead of granting
  assign tokValid = (tok <= decoder_used);
  assign beatXfer = (state == BURST) && mem_rd_vld && dec_rdy[tok];
  assign dec_data = mem_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (tokValid && dec_req[tok]) stateNext = CMD;
      CMD:     if (mem_cmd_rdy) stateNext = BURST;
      BURST:   if (beatXfer && cnt == '0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tok           <= '0;
      cnt           <= '0;
      usedLat       <= '0;
      mem_cmd_addr  <= '0;
      mem_cmd_burst <= '0;
    end else begin
      case (state)
        IDLE: begin
          // the wrap point is frozen here so mid-turn decoder_used changes wait for the next IDLE
          usedLat <= decoder_used;
          if (!tokValid) begin
            tok <= '0;
          end else if (dec_req[tok]) begin
            mem_cmd_addr  <= dec_addr[AW*32'(tok) +: AW];
            mem_cmd_burst <= dec_burst[BW*32'(tok) +: BW];
          end
        end
        CMD: begin
          if (mem_cmd_rdy) cnt <= mem_cmd_burst;
        end
        BURST: begin
          if (beatXfer) begin
            if (cnt == '0) begin
              tok <= (tok == usedLat) ? 3'd0 : tok + 3'd1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dec_grant   = '0;
    dec_vld     = '0;
    mem_cmd_vld = 1'b0;
    mem_rd_rdy  = 1'b0;
    busy        = 1'b0;
    case (state)
      CMD: begin
        dec_grant[tok] = 1'b1;
        mem_cmd_vld    = 1'b1;
        busy           = 1'b1;
      end
      BURST: begin
        dec_grant[tok] = 1'b1;
        dec_vld[tok]   = mem_rd_vld;
        mem_rd_rdy     = dec_rdy[tok];
        busy           = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_px_rd_sched.sv
// tb/tb_px_rd_sched.sv - scoreboard bench for px_rd_sched
module tb_px_rd_sched;

  logic         clk;
  logic         rst;
  logic [2:0]   decoder_used;
  logic [7:0]   dec_req;
  logic [159:0] dec_addr;
  logic [31:0]  dec_burst;
  logic [7:0]   dec_grant;
  logic [7:0]   dec_vld;
  logic [7:0]   dec_rdy;
  logic [15:0]  dec_data;
  logic         mem_cmd_vld;
  logic         mem_cmd_rdy;
  logic [19:0]  mem_cmd_addr;
  logic [3:0]   mem_cmd_burst;
  logic         mem_rd_vld;
  logic         mem_rd_rdy;
  logic [15:0]  mem_rd_data;
  logic         busy;
  logic [2:0]   tok;

  int checks = 0;
  int errors = 0;
  int expTok = 0;
  int expUsed = 0;
  logic [15:0] dataSeq;
  logic [26:0] cmdQ[$];
  logic [15:0] beatQ[$];

  px_rd_sched dut (
    .clk(clk), .rst(rst), .decoder_used(decoder_used),
    .dec_req(dec_req), .dec_addr(dec_addr), .dec_burst(dec_burst),
    .dec_grant(dec_grant), .dec_vld(dec_vld), .dec_rdy(dec_rdy), .dec_data(dec_data),
    .mem_cmd_vld(mem_cmd_vld), .mem_cmd_rdy(mem_cmd_rdy),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_burst(mem_cmd_burst),
    .mem_rd_vld(mem_rd_vld), .mem_rd_rdy(mem_rd_rdy), .mem_rd_data(mem_rd_data),
    .busy(busy), .tok(tok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int nextTok(input int t);
    return (t == expUsed) ? 0 : t + 1;
  endfunction

  // one full turn for decoder idx; entered at a negedge with the DUT idle and tok == idx
  task automatic runTurn(input int idx, input logic [19:0] addr, input logic [3:0] burst,
                         input int cmdWait, input int rdyMode, input int abortAt);
    logic [26:0] expCmd;
    logic [15:0] expBeat;
    logic        rdy;
    logic        pending;
    int          beat;
    int          cycles;
    dec_req[idx] = 1'b1;
    dec_addr[idx*20 +: 20] = addr;
    dec_burst[idx*4 +: 4] = burst;
    cmdQ.push_back({3'(idx), addr, burst});
    mem_cmd_rdy = 1'b0;
    @(negedge clk);
    checkEq("grant_cmd", dec_grant, 32'(8'(1) << idx));
    checkEq("busy_cmd", busy, 1);
    for (int w = 0; w < cmdWait; w++) begin
      checkEq("cmd_vld_hold", mem_cmd_vld, 1);
      checkEq("cmd_addr_hold", mem_cmd_addr, addr);
      checkEq("busy_hold", busy, 1);
      @(negedge clk);
    end
    checkEq("cmd_vld", mem_cmd_vld, 1);
    mem_cmd_rdy = 1'b1;
    if (cmdQ.size() == 0) begin
      checkEq("cmdq_empty", 0, 1);
    end else begin
      expCmd = cmdQ.pop_front();
      checkEq("cmd_tok", tok, expCmd[26:24]);
      checkEq("cmd_addr", mem_cmd_addr, expCmd[23:4]);
      checkEq("cmd_burst", mem_cmd_burst, expCmd[3:0]);
    end
    @(negedge clk);
    mem_cmd_rdy = 1'b0;
    dec_req[idx] = 1'b0;
    beat = 0;
    cycles = 0;
    pending = 1'b0;
    while (beat <= int'(burst) && cycles < 100) begin
      if (beat == abortAt) begin
        rst = 1'b1;
        mem_rd_vld = 1'b1;
        dec_rdy = 8'hFF;
        @(negedge clk);
        checkEq("abort_grant", dec_grant, 0);
        checkEq("abort_busy", busy, 0);
        checkEq("abort_tok", tok, 0);
        checkEq("abort_rd_rdy", mem_rd_rdy, 0);
        checkEq("abort_dec_vld", dec_vld, 0);
        checkEq("abort_cmd_addr", mem_cmd_addr, 0);
        beatQ.delete();
        rst = 1'b0;
        mem_rd_vld = 1'b0;
        dec_rdy = 8'h00;
        expTok = 0;
        return;
      end
      rdy = (rdyMode == 0) ? 1'b1 : (cycles % 2 == 0);
      dec_rdy = 8'($urandom);
      dec_rdy[idx] = rdy;
      if (!pending) begin
        mem_rd_data = dataSeq;
        beatQ.push_back(dataSeq);
        dataSeq = dataSeq + 16'd1;
        pending = 1'b1;
      end
      mem_rd_vld = 1'b1;
      #1;
      checkEq("rd_rdy_follow", mem_rd_rdy, rdy);
      checkEq("dec_vld", dec_vld, 32'(8'(1) << idx));
      if (dec_vld[idx] && dec_rdy[idx]) begin
        if (beatQ.size() == 0) begin
          checkEq("beatq_empty", 0, 1);
        end else begin
          expBeat = beatQ.pop_front();
          checkEq("beat_data", dec_data, expBeat);
        end
        pending = 1'b0;
        beat++;
      end
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 100) checkEq("burst_timeout", 0, 1);
    // an extra beat after the last one must not be acknowledged
    #1;
    checkEq("idle_rd_rdy", mem_rd_rdy, 0);
    checkEq("idle_dec_vld", dec_vld, 0);
    checkEq("idle_grant", dec_grant, 0);
    checkEq("idle_busy", busy, 0);
    expTok = nextTok(idx);
    checkEq("tok_next", tok, expTok);
    mem_rd_vld = 1'b0;
    dec_rdy = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    decoder_used = 3'd0;
    dec_req = 8'hFF;
    dec_addr = '0;
    dec_burst = '0;
    dec_rdy = 8'h00;
    mem_cmd_rdy = 1'b0;
    mem_rd_vld = 1'b0;
    mem_rd_data = 16'h0;
    dataSeq = 16'hE96A;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkEq("rst_grant", dec_grant, 0);
      checkEq("rst_vld", dec_vld, 0);
      checkEq("rst_cmd_vld", mem_cmd_vld, 0);
      checkEq("rst_rd_rdy", mem_rd_rdy, 0);
      checkEq("rst_cmd_addr", mem_cmd_addr, 0);
      checkEq("rst_cmd_burst", mem_cmd_burst, 0);
      checkEq("rst_busy", busy, 0);
      checkEq("rst_tok", tok, 0);
    end

    rst = 1'b0;
    decoder_used = 3'd1;
    expUsed = 1;
    dec_req = 8'b0000_0110;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkEq("ignore_grant", dec_grant, 0);
      checkEq("ignore_busy", busy, 0);
      checkEq("ignore_tok", tok, 0);
    end
    dec_req = 8'h00;

    runTurn(0, 20'h00010, 4'd2, 0, 0, -1);
    runTurn(1, 20'h00100, 4'd5, 0, 1, -1);

    decoder_used = 3'd7;
    expUsed = 7;
    dec_req = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      checkEq("order_tok", tok, 32'(i));
      runTurn(i, 20'h40000 + 20'(i * 'h111), 4'd15, (i == 3) ? 4 : 0, 0, -1);
    end
    runTurn(0, 20'h0ABCD, 4'd0, 0, 0, -1);
    for (int i = 1; i < 5; i++) begin
      runTurn(i, 20'h20000 + 20'(i), 4'(i), 0, i % 2, -1);
    end
    dec_req = 8'hFF;
    checkEq("pre_shrink_tok", tok, 5);
    decoder_used = 3'd2;
    expUsed = 2;
    @(negedge clk);
    checkEq("shrink_tok", tok, 0);
    checkEq("shrink_grant", dec_grant, 0);
    checkEq("shrink_busy", busy, 0);
    runTurn(0, 20'h0F0F0, 4'd7, 0, 0, 3);
    dec_req = 8'h00;
    @(negedge clk);
    checkEq("post_abort_busy", busy, 0);
    checkEq("post_abort_tok", tok, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/px_rd_sched.md
Name: px_rd_sched

Overview:
Ordered read scheduler between up to 8 pixel decoders and the single pixel-memory read port. Decoders take turns in strict token order (0,1,...,N-1, wrap). Each decoder holds a request with a 20-bit address and a 4-bit burst descriptor. The scheduler issues one command per turn to memory, then steers the returned beats to the token holder with valid/ready flow control.

Parameters:
NDEC, 8, number of decoder request slots
AW, 20, address width per decoder
DW, 16, pixel data width
BW, 4, burst field width (beats-1, so 0..15 means 1..16 beats)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
decoder_used  in  3  active decoder count minus 1; N = decoder_used+1 (1..8)
dec_req  in  NDEC  per-decoder read request, level, held until grant
dec_addr  in  NDEC*AW  decoder i address at [AW*i+AW-1 : AW*i]
dec_burst  in  NDEC*BW  decoder i burst (beats-1) at [BW*i+BW-1 : BW*i]
dec_grant  out  NDEC  one-hot, high for the token holder from CMD through last beat
dec_vld  out  NDEC  one-hot data valid toward the token holder
dec_rdy  in  NDEC  per-decoder data ready
dec_data  out  DW  shared read data bus
mem_cmd_vld  out  1  command valid to memory
mem_cmd_rdy  in  1  memory accepts command
mem_cmd_addr  out  AW  latched address
mem_cmd_burst  out  BW  latched burst
mem_rd_vld  in  1  memory data beat valid
mem_rd_rdy  out  1  ready back to memory
mem_rd_data  in  DW  memory data
busy  out  1  high in CMD or BURST
tok  out  3  current token index

Behaviour:
- Reset (rst=1 at edge): state=IDLE, tok=0, cnt=0. Outputs: dec_grant=0, dec_vld=0, mem_cmd_vld=0, mem_rd_rdy=0, mem_cmd_addr=0, mem_cmd_burst=0, busy=0. Reset mid-burst aborts immediately. Remaining memory beats are not acknowledged.
- FSM states: IDLE, CMD, BURST.
- IDLE:
  - If tok >= N (decoder_used lowered), set tok=0 next cycle and issue no grant that cycle.
  - Else if dec_req[tok]=1: latch addr/burst of slice tok, set dec_grant[tok]=1, go to CMD. Grant is visible the cycle after the request is sampled.
  - Requests from any other index, or index >= N, are ignored. The state does not change and there is no starvation bypass.
- CMD: mem_cmd_vld=1 with the latched addr/burst. When mem_cmd_rdy=1: load cnt=burst, go to BURST. mem_cmd_vld holds until accepted.
- BURST:
  - Combinational pass-through: dec_data=mem_rd_data, dec_vld[tok]=mem_rd_vld, mem_rd_rdy=dec_rdy[tok]. Zero added latency.
  - A beat transfers when mem_rd_vld & dec_rdy[tok].
  - On each transfer: if cnt==0, drop grant, set tok=(tok+1==N)?0:tok+1, go to IDLE. Else cnt=cnt-1.
  - dec_rdy from non-token decoders is ignored.
- Exactly burst+1 beats per grant; memory must not send more. Any extra beat in IDLE/CMD sees mem_rd_rdy=0.
- decoder_used is sampled only in IDLE. Changes during CMD/BURST take effect at the next IDLE.
- dec_req dropping after grant does not cancel the transaction.
- dec_data is don't-care outside BURST; drive mem_rd_data.
- Minimum turn: IDLE→CMD→BURST→IDLE. This is 3 cycles for a 1-beat burst with mem_cmd_rdy and data ready immediately.

Test Plan:
- Reset with rst=1 for 2 cycles, dec_req=8'hFF → all outputs 0, tok=0, no grant while rst high.
- decoder_used=1, dec_req=8'b0000_0110 (idx1,2 only) → no grant, state IDLE. Then set idx0 req, addr=20'h00010, burst=2, memory returns 3 beats 16'hE96A..E96C with dec_rdy[0]=1 → grant[0] for CMD+3 beats, mem_cmd_addr=0x00010, mem_cmd_burst=2, tok→1.
- tok=1, idx1 addr=20'h00100, burst=5, dec_rdy[1] toggled 1,0,1,... → 6 beats delivered, mem_rd_rdy follows dec_rdy[1], tok wraps to 0 (N=2).
- decoder_used=7, all requesting, burst=15 each → grants in order 0..7 then 0. 16 beats each, tok sequence 0,1,..,7,0.
- mem_cmd_rdy held low 4 cycles → mem_cmd_vld stays 1, addr stable, busy=1. Then accepted, BURST entered.
- tok=5 in IDLE, decoder_used changed 7→2 → next cycle tok=0, then idx0 request served. Assert rst mid-BURST at beat 3 of 8 → IDLE, tok=0, grant cleared next edge.
